parity_tx: RTL

Serial even-parity frame transmitter: accepts a DATA_W-bit word over a valid/ready handshake and serializes it LSB first as start bit, data bits, parity bit, stop bit. The parity bit makes the XOR of all data bits plus parity equal 0. The block is the transmitting end of the 4-data-bit + parity link whose receiving side computes `e = d0^d1^d2^d3^p`, where `e = 0` means a good word. It sits between the word source and the serial line.

---
 rtl/parity_tx_pkg.sv | 26 ++
 rtl/parity_tx_bit_timer.sv | 36 +++
 rtl/parity_tx.sv | 124 ++++++++++++
 3 files changed

// File: rtl/parity_tx_pkg.sv
// Purpose : shared types, line levels and the parity helper for the even-parity serial transmitter.
// Latency : n/a (package).
// Backpressure: n/a (package).
package parity_tx_pkg;

  // Frame sequencing states, in transmit order.
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  // Serial line levels.
  localparam logic IDLE_LVL  = 1'b1;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

  // Even parity bit: XOR of every data bit. Callers zero-extend their word,
  // which leaves the XOR unchanged.
  function automatic logic parity_of(input logic [63:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/parity_tx_bit_timer.sv
// Purpose : bit-period timer; counts 0..CLKS_PER_BIT-1 while enabled and flags the terminal count.
// Latency : bit_end is combinational from the counter, high on the last cycle of each bit period.
// Backpressure: none; load restarts the period at count 0.
//
// Ports: clk, rst_n (async, active low), en (count while high),
//        load (restart at 0, wins over en), bit_end (terminal-count flag).
module parity_tx_bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic load,
  output logic bit_end
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  assign bit_end = en && (cnt == LAST);

  // The counter wraps to 0 at the terminal count, so consecutive bit periods
  // run back to back without needing an explicit reload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/parity_tx.sv
// Purpose : even-parity serial frame transmitter (start, DATA_W data bits LSB first, parity, stop).
// Latency : start bit on tx_out one cycle after acceptance; frame lasts (DATA_W+3)*CLKS_PER_BIT cycles.
// Backpressure: ready_out is low for the whole frame; valid_in is ignored while busy (no queue).
//
// Ports: clk, rst_n (async, active low); data_in/valid_in/ready_out word handshake;
//        tx_out serial line (idles high); busy = !ready_out; frame_done pulses on the
//        last stop-bit cycle. Optional macro PARITY_TX_ERR_INJECT_EN adds err_inject,
//        sampled at acceptance, which inverts the parity bit of that one frame.
module parity_tx
  import parity_tx_pkg::*;
#(
  parameter int DATA_W       = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic              ready_out,
  output logic              tx_out,
  output logic              busy,
  output logic              frame_done
`ifdef PARITY_TX_ERR_INJECT_EN
  ,
  input  logic              err_inject
`endif
);

  localparam int BCW = $clog2(DATA_W + 1);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_W - 1);

  tx_state_t         state;
  logic [DATA_W-1:0] shift;
  logic              par;
  logic [BCW-1:0]    bit_cnt;
  logic              accept;
  logic              bit_end;
  logic              inject;

  // ready_out is only ever high in IDLE, so it alone qualifies acceptance.
  assign accept = valid_in && ready_out;

`ifdef PARITY_TX_ERR_INJECT_EN
  assign inject = err_inject;
`else
  assign inject = 1'b0;
`endif

  parity_tx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (state != IDLE),
    .load   (accept),
    .bit_end(bit_end)
  );

  // tx_out is registered from the current state, so the line trails the state
  // by one cycle. Ending STOP in the state domain one cycle early lets ready_out
  // and frame_done rise together on the final stop-bit cycle, which leaves a
  // single idle-high cycle between back-to-back frames.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      shift      <= '0;
      par        <= 1'b0;
      bit_cnt    <= '0;
      tx_out     <= IDLE_LVL;
      ready_out  <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          tx_out <= IDLE_LVL;
          if (accept) begin
            shift     <= data_in;
            par       <= parity_of(64'(data_in)) ^ inject;
            bit_cnt   <= '0;
            state     <= START;
            ready_out <= 1'b0;
            busy      <= 1'b1;
          end
        end
        START: begin
          tx_out <= START_LVL;
          if (bit_end) state <= DATA;
        end
        DATA: begin
          tx_out <= shift[0];
          if (bit_end) begin
            shift <= shift >> 1;
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              state   <= PARITY;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        PARITY: begin
          tx_out <= par;
          if (bit_end) state <= STOP;
        end
        STOP: begin
          tx_out <= STOP_LVL;
          if (bit_end) begin
            state      <= IDLE;
            ready_out  <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          tx_out <= IDLE_LVL;
        end
      endcase
    end
  end

endmodule
